serial_word_deserializer: RTL and testbench

//  Receive end of the serial link driven by the universal shift register.

---
 rtl/serial_word_deserializer.sv | 158 +++++++++++++++
 tb/tb_serial_word_deserializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: gathers an LSB- or MSB-first bit stream into WIDTH-bit words
// and hands them downstream through a one-word valid/ready holding register.
module serial_word_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_dir,
    input  logic                     i_d,
    input  logic                     i_d_valid,
    input  logic                     i_ready,
    input  logic                     i_clr_ovr,
    output logic [WIDTH-1:0]         o_word,
    output logic                     o_valid,
    output logic                     o_overrun,
    output logic                     o_busy,
    output logic [$clog2(WIDTH)-1:0] o_bit_cnt
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    logic              capture;
    logic              use_dir;
    logic [WIDTH-1:0]  base;
    logic [CntW-1:0]   idx;
    logic [WIDTH-1:0]  new_word;
    logic              word_done;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: abort beats start
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = StIdle;
        end else if (i_start) begin
            state_d = StRecv;
        end
    end

    // FSM outputs
    always_comb begin
        o_busy = (state_q == StRecv);
    end

    // Bit capture: a start discards the partial word and may capture bit 0 on the same edge.
    always_comb begin
        dir_d     = dir_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        use_dir   = dir_q;
        base      = shift_q;
        idx       = cnt_q;
        new_word  = '0;
        word_done = 1'b0;

        if (i_abort) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_start) begin
            dir_d   = i_dir;
            use_dir = i_dir;
            base    = '0;
            idx     = '0;
            shift_d = '0;
            cnt_d   = '0;
            capture = i_d_valid;
        end else if (state_q == StRecv) begin
            capture = i_d_valid;
        end

        if (capture) begin
            new_word = use_dir ? {i_d, base[WIDTH-1:1]} : {base[WIDTH-2:0], i_d};
            if (idx == LastIdx) begin
                word_done = 1'b1;
                shift_d   = '0;
                cnt_d     = '0;
            end else begin
                shift_d = new_word;
                cnt_d   = idx + CntW'(1);
            end
        end
    end

    // Holding register: a completed word reloads over an outgoing transfer without a bubble.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (word_done) begin
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end else begin
                word_d  = new_word;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_word    = word_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;
    assign o_bit_cnt = cnt_q;

`ifndef SYNTHESIS
    a_word_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (valid_q && !i_ready) |=> (valid_q && word_q == $past(word_q)));
    a_cnt_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        cnt_q <= LastIdx);
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer at WIDTH=4; each task drives one scenario
// and checks its own expected values.
module tb_serial_word_deserializer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dir;
    logic       d;
    logic       d_valid;
    logic       ready;
    logic       clr_ovr;
    logic [3:0] word;
    logic       valid;
    logic       overrun;
    logic       busy;
    logic [1:0] bit_cnt;

    int errors = 0;
    int checks = 0;

    serial_word_deserializer #(.WIDTH(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_abort  (abort),
        .i_dir    (dir),
        .i_d      (d),
        .i_d_valid(d_valid),
        .i_ready  (ready),
        .i_clr_ovr(clr_ovr),
        .o_word   (word),
        .o_valid  (valid),
        .o_overrun(overrun),
        .o_busy   (busy),
        .o_bit_cnt(bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic new_dir);
        start = 1'b1;
        dir   = new_dir;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        d_valid = 1'b1;
        d       = b;
        tick();
        d_valid = 1'b0;
        d       = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (word !== 4'h0) begin errors++; $display("FAIL reset_word: got %h need 0", word); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b need 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        checks++; if (bit_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d need 0", bit_cnt); end
        rst_n = 1'b1;
        tick();
        ready = 1'b1;
        pulse_start(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (bit_cnt !== 2'd2) begin errors++; $display("FAIL pre_rst_cnt: got %0d need 2", bit_cnt); end
        // Asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b need 0", busy); end
        checks++; if (bit_cnt !== 2'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d need 0", bit_cnt); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b need 0", valid); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b need 0", busy); end
        pulse_start(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b need 1", valid); end
        checks++; if (word !== 4'h3) begin errors++; $display("FAIL post_rst_word: got %h need 3", word); end
        tick();
    endtask

    // Bit 0 arrives on the start edge itself, from IDLE
    task automatic test_lsb_first();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b1;
        start   = 1'b1;
        dir     = 1'b1;
        d_valid = 1'b1;
        d       = 1'b1;
        tick();
        start   = 1'b0;
        d_valid = 1'b0;
        checks++; if (bit_cnt !== 2'd1) begin errors++; $display("FAIL lsb_start_capture: got %0d need 1", bit_cnt); end
        send_bit(1'b0);
        send_bit(1'b0);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lsb_early_valid: got %b need 0", valid); end
        send_bit(1'b1);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b need 1", valid); end
        checks++; if (word !== 4'b1001) begin errors++; $display("FAIL lsb_word: got %b need 1001", word); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lsb_valid_1cyc: got %b need 0", valid); end
    endtask

    task automatic test_msb_gaps();
        logic [3:0] bits;
        logic [1:0] cnt_exp [4];
        bits = 4'b1011;  // sent as bits[0], bits[1], ... = 1,1,0,1
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        ready = 1'b1;
        pulse_start(1'b0);
        dir = 1'b1;  // must be ignored until the next start
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i]);
            checks++;
            if (bit_cnt !== cnt_exp[i]) begin
                errors++; $display("FAIL msb_cnt[%0d]: got %0d need %0d", i, bit_cnt, cnt_exp[i]);
            end
            if (i == 3) begin
                checks++; if (word !== 4'b1101) begin errors++; $display("FAIL msb_word: got %b need 1101", word); end
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b need 1", valid); end
            end
            tick();
            tick();
            checks++;
            if (bit_cnt !== cnt_exp[i] || busy !== 1'b1) begin
                errors++; $display("FAIL msb_gap_hold[%0d]: cnt %0d busy %b need %0d 1", i, bit_cnt, busy, cnt_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] a_bits;
        logic [3:0] t_bits;
        a_bits = 4'hA;
        t_bits = 4'h3;
        ready = 1'b0;
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send_bit(a_bits[i]);
        checks++; if (word !== 4'hA || valid !== 1'b1) begin errors++; $display("FAIL bp_first: word %h valid %b need a 1", word, valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_ovr: got %b need 0", overrun); end
        for (int i = 0; i < 4; i++) send_bit(t_bits[i]);
        checks++; if (word !== 4'hA) begin errors++; $display("FAIL bp_word_kept: got %h need a", word); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid_kept: got %b need 1", valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr: got %b need 1", overrun); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || word !== 4'hA) begin errors++; $display("FAIL bp_xfer: valid %b word %h need 0 a", valid, word); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr_sticky: got %b need 1", overrun); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr: got %b need 0", overrun); end
        // Set and clear on the same edge: set wins
        for (int i = 0; i < 4; i++) send_bit(a_bits[i]);
        for (int i = 0; i < 3; i++) send_bit(t_bits[i]);
        clr_ovr = 1'b1;
        send_bit(t_bits[3]);
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_set_wins: got %b need 1", overrun); end
        ready   = 1'b1;
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL bp_cleanup: ovr %b valid %b need 0 0", overrun, valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b0011_1010;  // MSB-first 0,1,0,1 then 1,1,0,0
        ready = 1'b0;
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready = 1'b1;
            send_bit(bits[i]);
            if (i == 3) begin
                checks++; if (word !== 4'h5 || valid !== 1'b1) begin errors++; $display("FAIL b2b_word0: word %h valid %b need 5 1", word, valid); end
            end
            if (i == 6) begin
                checks++; if (word !== 4'h5) begin errors++; $display("FAIL b2b_hold0: got %h need 5", word); end
            end
        end
        checks++; if (word !== 4'hC) begin errors++; $display("FAIL b2b_word1: got %h need c", word); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got %b need 1", valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr: got %b need 0", overrun); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b need 0", valid); end
    endtask

    task automatic test_restart_abort();
        ready = 1'b1;
        pulse_start(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_start(1'b0);
        checks++; if (bit_cnt !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart_cnt: cnt %0d busy %b need 0 1", bit_cnt, busy); end
        ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (word !== 4'hA || valid !== 1'b1) begin errors++; $display("FAIL restart_word: word %h valid %b need a 1", word, valid); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (bit_cnt !== 2'd3) begin errors++; $display("FAIL abort_pre_cnt: got %0d need 3", bit_cnt); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || bit_cnt !== 2'd0) begin errors++; $display("FAIL abort_idle: busy %b cnt %0d need 0 0", busy, bit_cnt); end
        checks++; if (valid !== 1'b1 || word !== 4'hA) begin errors++; $display("FAIL abort_keep: valid %b word %h need 1 a", valid, word); end
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (bit_cnt !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ignore: cnt %0d busy %b need 0 0", bit_cnt, busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_no_ovr: got %b need 0", overrun); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_drain: got %b need 0", valid); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        dir     = 1'b0;
        d       = 1'b0;
        d_valid = 1'b0;
        ready   = 1'b0;
        clr_ovr = 1'b0;
        #3;
        test_reset();
        test_lsb_first();
        test_msb_gaps();
        test_backpressure();
        test_back_to_back();
        test_restart_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
